// File: rtl/ex_vector_stage.sv
// Execute stage: scalar ops finish in one cycle; a 6-lane vector op is computed
// one 32-bit lane per cycle while the ID/EX register is held by stall_out.
module ex_vector_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic         VectorOp_in,
    input  logic [1:0]   ALUOp_in,
    input  logic [1:0]   ALUSrc2_in,
    input  logic [31:0]  RSS2_in,
    input  logic [31:0]  RSS3_in,
    input  logic [191:0] RVS2_in,
    input  logic [191:0] RVS3_in,
    input  logic [31:0]  num_in,
    input  logic [3:0]   RD_in,
    input  logic         RegSWrite_in,
    input  logic         RegVWrite_in,
    output logic         stall_out,
    output logic         valid_out,
    output logic [31:0]  scalar_res_out,
    output logic [191:0] vector_res_out,
    output logic         zero_out,
    output logic [3:0]   RD_out,
    output logic         RegSWrite_out,
    output logic         RegVWrite_out
);

    typedef enum logic {IDLE, VEC_BUSY} state_t;

    function automatic logic [31:0] aluCalc(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a * b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       lane_q, lane_d;
    logic [1:0]       op_q, op_d;
    logic [5:0][31:0] vecA_q, vecA_d;
    logic [5:0][31:0] vecB_q, vecB_d;
    logic [5:0][31:0] acc_q, acc_d;
    logic [3:0]       rdLatch_q, rdLatch_d;
    logic             sWrLatch_q, sWrLatch_d;
    logic             vWrLatch_q, vWrLatch_d;

    logic             valid_q, valid_d;
    logic [31:0]      scalar_q, scalar_d;
    logic [191:0]     vector_q, vector_d;
    logic             zero_q, zero_d;
    logic [3:0]       rdOut_q, rdOut_d;
    logic             sWrOut_q, sWrOut_d;
    logic             vWrOut_q, vWrOut_d;

    logic [31:0]      scalarB;
    logic [191:0]     vectorB;
    logic [31:0]      scalarRes;
    logic [31:0]      laneRes;

    always_comb begin
        case (ALUSrc2_in)
            2'b01:   scalarB = num_in;
            default: scalarB = RSS3_in;
        endcase
        case (ALUSrc2_in)
            2'b01:   vectorB = {6{num_in}};
            2'b10:   vectorB = {6{RSS3_in}};
            default: vectorB = RVS3_in;
        endcase
        scalarRes = aluCalc(ALUOp_in, RSS2_in, scalarB);
        laneRes   = aluCalc(op_q, vecA_q[lane_q], vecB_q[lane_q]);
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        op_d       = op_q;
        vecA_d     = vecA_q;
        vecB_d     = vecB_q;
        acc_d      = acc_q;
        rdLatch_d  = rdLatch_q;
        sWrLatch_d = sWrLatch_q;
        vWrLatch_d = vWrLatch_q;
        valid_d    = 1'b0;
        scalar_d   = scalar_q;
        vector_d   = vector_q;
        zero_d     = zero_q;
        rdOut_d    = rdOut_q;
        sWrOut_d   = 1'b0;
        vWrOut_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (VectorOp_in) begin
                        state_d    = VEC_BUSY;
                        lane_d     = 3'd0;
                        op_d       = ALUOp_in;
                        vecA_d     = RVS2_in;
                        vecB_d     = vectorB;
                        acc_d      = '0;
                        rdLatch_d  = RD_in;
                        sWrLatch_d = RegSWrite_in;
                        vWrLatch_d = RegVWrite_in;
                    end else begin
                        valid_d  = 1'b1;
                        scalar_d = scalarRes;
                        zero_d   = (scalarRes == 32'd0);
                        rdOut_d  = RD_in;
                        sWrOut_d = RegSWrite_in;
                        vWrOut_d = RegVWrite_in;
                    end
                end
            end
            VEC_BUSY: begin
                acc_d[lane_q] = laneRes;
                if (lane_q == 3'd5) begin
                    // Last lane: publish the assembled vector including this lane.
                    state_d  = IDLE;
                    lane_d   = 3'd0;
                    valid_d  = 1'b1;
                    vector_d = acc_d;
                    zero_d   = (acc_d == '0);
                    rdOut_d  = rdLatch_q;
                    sWrOut_d = sWrLatch_q;
                    vWrOut_d = vWrLatch_q;
                end else begin
                    lane_d = lane_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= 3'd0;
            op_q       <= 2'd0;
            vecA_q     <= '0;
            vecB_q     <= '0;
            acc_q      <= '0;
            rdLatch_q  <= 4'd0;
            sWrLatch_q <= 1'b0;
            vWrLatch_q <= 1'b0;
            valid_q    <= 1'b0;
            scalar_q   <= 32'd0;
            vector_q   <= '0;
            zero_q     <= 1'b0;
            rdOut_q    <= 4'd0;
            sWrOut_q   <= 1'b0;
            vWrOut_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            op_q       <= op_d;
            vecA_q     <= vecA_d;
            vecB_q     <= vecB_d;
            acc_q      <= acc_d;
            rdLatch_q  <= rdLatch_d;
            sWrLatch_q <= sWrLatch_d;
            vWrLatch_q <= vWrLatch_d;
            valid_q    <= valid_d;
            scalar_q   <= scalar_d;
            vector_q   <= vector_d;
            zero_q     <= zero_d;
            rdOut_q    <= rdOut_d;
            sWrOut_q   <= sWrOut_d;
            vWrOut_q   <= vWrOut_d;
        end
    end

    assign stall_out      = (state_q == VEC_BUSY);
    assign valid_out      = valid_q;
    assign scalar_res_out = scalar_q;
    assign vector_res_out = vector_q;
    assign zero_out       = zero_q;
    assign RD_out         = rdOut_q;
    assign RegSWrite_out  = sWrOut_q;
    assign RegVWrite_out  = vWrOut_q;

endmodule

// File: tb/tb_ex_vector_stage.sv
// Scoreboard bench for ex_vector_stage: directed vectors push expected results,
// a negedge monitor pops and compares on every valid_out pulse.
module tb_ex_vector_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in, VectorOp_in;
    logic [1:0]   ALUOp_in, ALUSrc2_in;
    logic [31:0]  RSS2_in, RSS3_in, num_in;
    logic [191:0] RVS2_in, RVS3_in;
    logic [3:0]   RD_in;
    logic         RegSWrite_in, RegVWrite_in;
    logic         stall_out, valid_out, zero_out;
    logic [31:0]  scalar_res_out;
    logic [191:0] vector_res_out;
    logic [3:0]   RD_out;
    logic         RegSWrite_out, RegVWrite_out;

    typedef struct packed {
        logic [31:0]  s;
        logic [191:0] v;
        logic         z;
        logic [3:0]   rd;
        logic         sw;
        logic         vw;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    bit           monitorOn = 1'b0;
    logic [31:0]  lastS = '0;
    logic [191:0] lastV = '0;

    ex_vector_stage dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .VectorOp_in(VectorOp_in),
        .ALUOp_in(ALUOp_in), .ALUSrc2_in(ALUSrc2_in), .RSS2_in(RSS2_in),
        .RSS3_in(RSS3_in), .RVS2_in(RVS2_in), .RVS3_in(RVS3_in), .num_in(num_in),
        .RD_in(RD_in), .RegSWrite_in(RegSWrite_in), .RegVWrite_in(RegVWrite_in),
        .stall_out(stall_out), .valid_out(valid_out),
        .scalar_res_out(scalar_res_out), .vector_res_out(vector_res_out),
        .zero_out(zero_out), .RD_out(RD_out), .RegSWrite_out(RegSWrite_out),
        .RegVWrite_out(RegVWrite_out)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] pack6(input logic [31:0] l0, l1, l2, l3, l4, l5);
        return {l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [191:0] actual,
                               input logic [191:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vec, input logic [1:0] op, src,
                                 input logic [31:0] a, b, num,
                                 input logic [191:0] va, vb,
                                 input logic [3:0] rd, input logic sw, vw);
        valid_in = 1'b1; VectorOp_in = vec; ALUOp_in = op; ALUSrc2_in = src;
        RSS2_in = a; RSS3_in = b; num_in = num; RVS2_in = va; RVS3_in = vb;
        RD_in = rd; RegSWrite_in = sw; RegVWrite_in = vw;
    endtask

    task automatic expectResult(input logic isVec, input logic [31:0] sRes,
                                input logic [191:0] vRes, input logic [3:0] rd,
                                input logic sw, vw);
        exp_t e;
        if (isVec) lastV = vRes; else lastS = sRes;
        e.s = lastS; e.v = lastV;
        e.z = isVec ? (vRes == '0) : (sRes == 32'd0);
        e.rd = rd; e.sw = sw; e.vw = vw;
        sb.push_back(e);
    endtask

    task automatic runScalar(input logic [1:0] op, src, input logic [31:0] a, b, num,
                             input logic [3:0] rd, input logic sw, vw,
                             input logic [31:0] expRes);
        @(negedge clk);
        applyStimulus(1'b0, op, src, a, b, num, '0, '0, rd, sw, vw);
        expectResult(1'b0, expRes, '0, rd, sw, vw);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    // Busy-window inputs are deliberately live garbage to show they are ignored.
    task automatic runVector(input logic [1:0] op, src, input logic [31:0] b, num,
                             input logic [191:0] va, vb, input logic [3:0] rd,
                             input logic sw, vw, input logic [191:0] expRes);
        @(negedge clk);
        applyStimulus(1'b1, op, src, 32'd0, b, num, va, vb, rd, sw, vw);
        expectResult(1'b1, 32'd0, expRes, rd, sw, vw);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall k=%0d", k), stall_out, (k <= 6) ? 1'b1 : 1'b0);
            if (k == 1) begin
                VectorOp_in = k[0]; RSS2_in = $urandom; RSS3_in = $urandom;
                RVS2_in = {6{$urandom}}; RD_in = 4'hF;
            end
            if (k == 7) valid_in = 1'b0;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " stall"}, stall_out, 0);
        checkOutput({tag, " valid"}, valid_out, 0);
        checkOutput({tag, " scalar"}, scalar_res_out, 0);
        checkOutput({tag, " vector"}, vector_res_out, 0);
        checkOutput({tag, " zero"}, zero_out, 0);
        checkOutput({tag, " rd"}, RD_out, 0);
        checkOutput({tag, " sw"}, RegSWrite_out, 0);
        checkOutput({tag, " vw"}, RegVWrite_out, 0);
    endtask

    always @(negedge clk) begin
        if (monitorOn) begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    checkOutput("valid_out with empty scoreboard", valid_out, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("scalar_res_out", scalar_res_out, e.s);
                    checkOutput("vector_res_out", vector_res_out, e.v);
                    checkOutput("zero_out", zero_out, e.z);
                    checkOutput("RD_out", RD_out, e.rd);
                    checkOutput("RegSWrite_out", RegSWrite_out, e.sw);
                    checkOutput("RegVWrite_out", RegVWrite_out, e.vw);
                end
            end else begin
                checkOutput("RegSWrite_out idle", RegSWrite_out, 0);
                checkOutput("RegVWrite_out idle", RegVWrite_out, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; VectorOp_in = 1'b0; ALUOp_in = 2'd0;
        ALUSrc2_in = 2'd0; RSS2_in = '0; RSS3_in = '0; num_in = '0;
        RVS2_in = '0; RVS3_in = '0; RD_in = '0; RegSWrite_in = 1'b0; RegVWrite_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        monitorOn = 1'b1;

        runScalar(2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 4'd3, 1'b1, 1'b0, 32'd12);
        RSS2_in = 32'hFFFF; VectorOp_in = 1'b1;
        repeat (3) @(negedge clk);

        runVector(2'b00, 2'b01, 32'd0, 32'd10, pack6(1, 2, 3, 4, 5, 6), '0,
                  4'd5, 1'b0, 1'b1, pack6(11, 12, 13, 14, 15, 16));
        runScalar(2'b01, 2'b00, 32'd0, 32'd1, 32'd0, 4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        runVector(2'b11, 2'b11, 32'd0, 32'd0, pack6(32'hDEADBEEF, 1, 2, 3, 4, 5),
                  pack6(32'hDEADBEEF, 1, 2, 3, 4, 5), 4'd7, 1'b0, 1'b1, '0);
        runScalar(2'b11, 2'b01, 32'hF0F0F0F0, 32'd0, 32'h0FF00FF0, 4'd2, 1'b1, 1'b0,
                  32'hFF00FF00);
        runScalar(2'b10, 2'b10, 32'h10000, 32'h10000, 32'd0, 4'd4, 1'b1, 1'b1, 32'd0);
        runVector(2'b10, 2'b10, 32'd3, 32'd0,
                  pack6(1, 2, 3, 32'h80000000, 32'hFFFFFFFF, 7), '0, 4'd9, 1'b0, 1'b1,
                  pack6(3, 6, 9, 32'h80000000, 32'hFFFFFFFD, 21));
        repeat (2) @(negedge clk);

        // Reset lands on the third busy edge; the partial vector must vanish.
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0,
                      pack6(9, 9, 9, 9, 9, 9), pack6(1, 1, 1, 1, 1, 1), 4'd6, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) valid_in = 1'b0;
            if (k <= 3) checkOutput($sformatf("midrst stall k=%0d", k), stall_out, 1);
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                checkAllZero("midrst");
                rst = 1'b0;
                lastS = '0;
                lastV = '0;
            end
            if (k > 4) checkOutput($sformatf("midrst stall k=%0d", k), stall_out, 0);
        end

        // Back-to-back: scalar mul waits on the bus through the whole stall.
        @(negedge clk);
        applyStimulus(1'b1, 2'b01, 2'b00, 32'd0, 32'd0, 32'd0,
                      pack6(10, 0, 5, 100, 0, 1), pack6(3, 1, 5, 1, 0, 2), 4'd11, 1'b0, 1'b1);
        expectResult(1'b1, 32'd0, pack6(7, 32'hFFFFFFFF, 0, 99, 0, 32'hFFFFFFFF),
                     4'd11, 1'b0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                applyStimulus(1'b0, 2'b10, 2'b00, 32'd3, 32'd4, 32'd0, '0, '0,
                              4'd12, 1'b1, 1'b0);
                expectResult(1'b0, 32'd12, '0, 4'd12, 1'b1, 1'b0);
            end
            checkOutput($sformatf("b2b stall k=%0d", k), stall_out, (k <= 6) ? 1'b1 : 1'b0);
            if (k == 7) checkOutput("b2b vector valid T+7", valid_out, 1);
            if (k == 8) begin
                checkOutput("b2b scalar valid T+8", valid_out, 1);
                valid_in = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_vector_stage.md
EX_VECTOR_STAGE -- requirements
Module: ex_vector_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high (ports named clk and rst).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 valid_in  input  1  upstream ID/EX register holds a valid instruction.
REQ-005 VectorOp_in  input  1  1 = vector op on 192-bit operands, 0 = scalar op on 32-bit operands.
REQ-006 ALUOp_in  input  2  00 add, 01 sub, 10 mul (low 32 bits), 11 xor.
REQ-007 ALUSrc2_in  input  2  operand B: 00 RSS3/RVS3 lane, 01 num_in broadcast, 10 RSS3_in broadcast, 11 same as 00.
REQ-008 RSS2_in, RSS3_in  input  32 each  scalar operands A and B.
REQ-009 RVS2_in, RVS3_in  input  192 each  vector operands A and B.
REQ-010 num_in  input  32  immediate.
REQ-011 RD_in  input  4  destination register.
REQ-012 RegSWrite_in, RegVWrite_in  input  1 each  write enables, carried with the result.
REQ-013 stall_out  output  1  upstream holds the ID/EX contents while high.
REQ-014 valid_out  output  1  one-cycle pulse, result outputs valid.
REQ-015 scalar_res_out  output  32; vector_res_out  output  192; zero_out  output  1.
REQ-016 RD_out  output  4; RegSWrite_out, RegVWrite_out  output  1 each.

Function
REQ-017 Vectors SHALL be 6 lanes of 32 bits; lane i = bits [32i+31:32i], lane 0 at the LSBs.
REQ-018 Arithmetic SHALL be modulo 2^32 per lane; mul SHALL return the low 32 bits of the unsigned product; no carries SHALL cross lanes.
REQ-019 FSM SHALL have two states, IDLE and VEC_BUSY; stall_out SHALL equal (state == VEC_BUSY).
REQ-020 In IDLE with valid_in=1 and VectorOp_in=0, the block SHALL register the scalar result and assert valid_out on the next cycle (latency 1), staying in IDLE.
REQ-021 In IDLE with valid_in=1 and VectorOp_in=1 at edge T, the block SHALL latch operands, the op, RD and the write enables, clear the lane counter to 0, and enter VEC_BUSY.
REQ-022 In VEC_BUSY the block SHALL compute one lane per cycle, lanes 0..5 in cycles T+1..T+6, and ignore all inputs.
REQ-023 After lane 5, the block SHALL return to IDLE and pulse valid_out in cycle T+7 with the full vector_res_out; stall_out SHALL be high for exactly 6 cycles.
REQ-024 In cycle T+7 (IDLE), a new valid_in SHALL be accepted, so back-to-back instructions lose no cycles.
REQ-025 For scalar ops, zero_out SHALL be (scalar_res_out == 0); for vector ops, zero_out SHALL be 1 only if all 6 lanes are zero.
REQ-026 RegSWrite_out and RegVWrite_out SHALL be 0 whenever valid_out=0, and SHALL equal the latched values when valid_out=1.
REQ-027 Result, zero and RD outputs SHALL hold their last values between valid_out pulses.
REQ-028 valid_in=0 in IDLE SHALL leave the state unchanged with valid_out=0.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, lane counter 0, and set all outputs to 0 (stall_out, valid_out, scalar_res_out, vector_res_out, zero_out, RD_out, RegSWrite_out, RegVWrite_out).
REQ-030 rst during VEC_BUSY SHALL discard the partial result; no valid_out SHALL follow for that instruction.
REQ-031 rst SHALL take priority over a simultaneous valid_in.

Verification
REQ-032 Reset: hold rst for 2 cycles -> all outputs 0, stall_out 0.
REQ-033 Scalar add: RSS2=5, RSS3=7, ALUSrc2=00, ALUOp=00 -> next cycle valid_out=1, scalar_res_out=12, zero_out=0.
REQ-034 Vector immediate add: RVS2 lanes {1,2,3,4,5,6}, num_in=10, ALUSrc2=01 -> stall_out high T+1..T+6; valid_out at T+7 with lanes {11,12,13,14,15,16}.
REQ-035 Wrap and zero: scalar sub 0-1 -> 0xFFFFFFFF, zero_out=0; vector xor with RVS2=RVS3 -> all lanes 0, zero_out=1.
REQ-036 Reset mid-op: vector op accepted at T, rst at T+3 -> stall_out 0 from T+4, no valid_out through T+10.
REQ-037 Back-to-back: vector at T, scalar mul 3*4 held during stall -> vector valid_out at T+7, scalar accepted at T+7, valid_out at T+8 with 12.
